// File: rtl/pool_window_fetch.sv
// Walks a row-major feature map in BRAM and gathers each non-overlapping X*Y
// pooling window into one flattened vector behind a valid/ready handshake.
module pool_window_fetch #(
  parameter int DEPTH  = 8,
  parameter int X      = 3,
  parameter int Y      = 3,
  parameter int IMG_W  = 9,
  parameter int IMG_H  = 9,
  parameter int ADDR_W = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_en,
  output logic [ADDR_W-1:0]     bram_addr,
  input  logic [DEPTH-1:0]      bram_dout,
  output logic [DEPTH*X*Y-1:0]  win_data,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [ADDR_W-1:0]     win_col,
  output logic [ADDR_W-1:0]     win_row
);

  localparam int NWC    = IMG_W / X;
  localparam int NWR    = IMG_H / Y;
  localparam int NPIX   = X * Y;
  localparam int LANE_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam bit NO_WIN = (NWC == 0) || (NWR == 0);

  localparam logic [ADDR_W-1:0] X_LAST  = ADDR_W'(X - 1);
  localparam logic [ADDR_W-1:0] Y_LAST  = ADDR_W'(Y - 1);
  localparam logic [ADDR_W-1:0] WC_LAST = ADDR_W'(NWC - 1);
  localparam logic [ADDR_W-1:0] WR_LAST = ADDR_W'(NWR - 1);
  localparam logic [ADDR_W-1:0] X_A     = ADDR_W'(X);
  localparam logic [ADDR_W-1:0] Y_A     = ADDR_W'(Y);
  localparam logic [ADDR_W-1:0] W_A     = ADDR_W'(IMG_W);

  typedef enum logic [2:0] {IDLE, READ, FILL, PRESENT, DONE} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pix_i_reg, pix_j_reg, wc_reg, wr_reg;
  logic [LANE_W-1:0]   lane_reg, cap_lane_reg;
  logic                cap_en_reg;
  logic                last_read, last_win, xfer;

  assign last_read = (pix_i_reg == X_LAST) && (pix_j_reg == Y_LAST);
  assign last_win  = (wc_reg == WC_LAST) && (wr_reg == WR_LAST);
  assign xfer      = (state_reg == PRESENT) && win_ready;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = NO_WIN ? DONE : READ;
      READ:    if (last_read) state_next = FILL;
      FILL:    state_next = PRESENT;
      PRESENT: if (win_ready) state_next = last_win ? DONE : READ;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pixel counters stop on the final read so bram_addr keeps its last value
  // until the next window's reads begin.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_i_reg    <= '0;
      pix_j_reg    <= '0;
      wc_reg       <= '0;
      wr_reg       <= '0;
      lane_reg     <= '0;
      cap_lane_reg <= '0;
      cap_en_reg   <= 1'b0;
    end else begin
      cap_en_reg   <= (state_reg == READ);
      cap_lane_reg <= lane_reg;
      if (state_reg == IDLE && start) begin
        pix_i_reg <= '0;
        pix_j_reg <= '0;
        wc_reg    <= '0;
        wr_reg    <= '0;
        lane_reg  <= '0;
      end
      if (state_reg == READ && !last_read) begin
        lane_reg <= lane_reg + 1'b1;
        if (pix_i_reg == X_LAST) begin
          pix_i_reg <= '0;
          pix_j_reg <= pix_j_reg + 1'b1;
        end else begin
          pix_i_reg <= pix_i_reg + 1'b1;
        end
      end
      if (xfer && !last_win) begin
        pix_i_reg <= '0;
        pix_j_reg <= '0;
        lane_reg  <= '0;
        if (wc_reg == WC_LAST) begin
          wc_reg <= '0;
          wr_reg <= wr_reg + 1'b1;
        end else begin
          wc_reg <= wc_reg + 1'b1;
        end
      end
    end
  end

  assign bram_addr = (wr_reg * Y_A + pix_j_reg) * W_A + wc_reg * X_A + pix_i_reg;

  // Each lane captures the BRAM word one cycle after its read was issued.
  for (genvar gi = 0; gi < NPIX; gi++) begin : g_lane
    logic [DEPTH-1:0] pix_reg;
    always_ff @(posedge clk) begin
      if (rst) pix_reg <= '0;
      else if (cap_en_reg && cap_lane_reg == LANE_W'(gi)) pix_reg <= bram_dout;
    end
    assign win_data[gi*DEPTH +: DEPTH] = pix_reg;
  end

  assign busy      = (state_reg == READ) || (state_reg == FILL) || (state_reg == PRESENT);
  assign done      = (state_reg == DONE);
  assign bram_en   = (state_reg == READ);
  assign win_valid = (state_reg == PRESENT);
  assign win_col   = wc_reg;
  assign win_row   = wr_reg;

endmodule

// File: doc/pool_window_fetch.md
Name: pool_window_fetch

Overview:
- Upstream feeder for the combinational max-pool stage.
- Walks a feature map stored row-major in a single-port BRAM with 1-cycle read latency.
- Gathers each non-overlapping X×Y pooling window (stride X horizontally, Y vertically) into one flattened vector, and presents it to the max-pool stage over a valid/ready handshake.

Parameters:
- DEPTH, 8, bits per pixel.
- X, 3, window width in pixels (columns).
- Y, 3, window height in pixels (rows).
- IMG_W, 9, feature-map width in pixels.
- IMG_H, 9, feature-map height in pixels.
- ADDR_W, 7, BRAM address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a full-map pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last window is accepted.
- bram_en  out  1  read enable.
- bram_addr  out  ADDR_W  read address.
- bram_dout  in  DEPTH  read data; valid the cycle after bram_en.
- win_data  out  DEPTH*X*Y  window vector; pixel (col i, row j) in bits [(j*X+i+1)*DEPTH-1 -: DEPTH].
- win_valid  out  1  win_data holds a complete window.
- win_ready  in  1  downstream accepts the window.
- win_col  out  ADDR_W  window column index (0..IMG_W/X-1).
- win_row  out  ADDR_W  window row index (0..IMG_H/Y-1).

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal counters 0.
- Reset asserted mid-pass aborts the pass: next cycle is IDLE with all outputs 0, no done pulse, and partial window data discarded.
- Window grid: NWC = floor(IMG_W/X), NWR = floor(IMG_H/Y). Leftover edge pixels are never read.
- Window order: win_col increments first, then win_row.
- Pixel (i,j) of window (wc,wr) is read from address (wr*Y+j)*IMG_W + wc*X + i. Reads are issued in j-outer, i-inner order, one per cycle.
- FSM states:
  - IDLE: busy=0. When start=1, go to READ.
  - READ: bram_en=1 for exactly X*Y consecutive cycles with the addresses above. Data from the read issued in cycle k is written into its lane at the end of cycle k+1. After the last read, go to FILL.
  - FILL: one cycle in which the final pixel is captured, then go to PRESENT.
  - PRESENT: win_valid=1. win_data, win_col and win_row stay stable until win_valid & win_ready.
    - On transfer, advance the window indices. If the accepted window was the last one, go to DONE; otherwise go to READ, with the first read of the next window in the next cycle.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- bram_en=0 in every state except READ. bram_addr is don't-care when bram_en=0 but holds its last value.
- Timing when start is sampled at edge t:
  - busy=1 from cycle t+1.
  - Reads occur in cycles t+1 .. t+X*Y.
  - win_valid rises in cycle t+X*Y+2.
- With win_ready tied high, window period is X*Y+2 cycles.
- start while busy is ignored; it is not queued.
- win_ready while win_valid=0 has no effect.
- Zero-window map (IMG_W<X or IMG_H<Y): go IDLE → DONE directly, with no reads and one done pulse.
- Lanes compare unsigned downstream. This block does not alter pixel values.

Test Plan:
- Defaults, BRAM mem[a]=a, win_ready=1, start pulse at edge t:
  - First reads hit 0,1,2,9,10,11,18,19,20.
  - win_valid in cycle t+11 with lanes 0..8 = {0,1,2,9,10,11,18,19,20} and win_col=0, win_row=0. Downstream max = 20.
- Same setup, run to completion:
  - 9 windows at period 11. Last window (col 2, row 2) has lanes {60,61,62,69,70,71,78,79,80} with max 80.
  - done pulses in cycle t+100; busy drops in the same cycle.
- Backpressure: hold win_ready=0 for 5 cycles after the first win_valid.
  - win_data and indices stay stable and bram_en stays 0.
  - Read of address 3 starts the cycle after win_ready rises.
- IMG_W=10, IMG_H=7:
  - Exactly 6 windows (3 cols × 2 rows); column 9 and row 6 are never addressed.
  - Second window begins at address 3; fourth window begins at address 30.
- Pulse start again during the 4th window: no effect, and exactly one done pulse.
- Assert rst for one cycle during READ of window 2:
  - All outputs 0 next cycle and no done pulse.
  - A fresh start restarts at window (0,0), address 0.
